pulse_wave_decoder: RTL

//  Receive-side counterpart of the waveform generators: recovers timing of a 1-bit
//  PWM/pulse waveform (Sine/Saw/Tri/Square pulse outputs) on the sysclk domain.
//  Per pulse period reports high-time (Duty) and period (Period) in sysclk cycles with a
//  one-cycle Sample_Valid strobe; flags a stuck line (0%/100% duty or dead generator).

---
 rtl/pulse_wave_decoder_pkg.sv | 9 +
 rtl/pulse_wave_decoder_sync_edge.sv | 32 +++
 rtl/pulse_wave_decoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/pulse_wave_decoder_pkg.sv
// pulse_wave_decoder_pkg: shared FSM state encodings for the pulse wave decoder
package pulse_wave_decoder_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } state_e;
endpackage

// File: rtl/pulse_wave_decoder_sync_edge.sv
// pulse_sync_edge: synchronizes an async pulse line and derives rise/fall strobes
//   clk_i   : sampling clock
//   rst_ni  : async active-low reset, clears all flops
//   pulse_i : asynchronous input line
//   s_o     : synchronized level
//   rise_o  : s_o went 0->1 this cycle
//   fall_o  : s_o went 1->0 this cycle
module pulse_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pulse_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic s_d_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end
  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~s_d_q;
  assign fall_o = ~s_o & s_d_q;
endmodule

// File: rtl/pulse_wave_decoder.sv
// pulse_wave_decoder: measures high-time and period of a 1-bit pulse waveform
//   sysclk       : system clock
//   reset        : async active-low reset
//   En           : enable; low forces idle and clears counters/flags
//   Pulse        : asynchronous waveform under measurement
//   Duty         : high-time of last complete period (sysclk cycles)
//   Period       : rise-to-rise length of last complete period
//   Sample_Valid : one-cycle strobe when Duty/Period update
//   Stuck_High   : no rise for TIMEOUT cycles, line high
//   Stuck_Low    : no rise for TIMEOUT cycles, line low
module pulse_wave_decoder
  import pulse_wave_decoder_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             En,
  input  logic             Pulse,
  output logic [CNT_W-1:0] Duty,
  output logic [CNT_W-1:0] Period,
  output logic             Sample_Valid,
  output logic             Stuck_High,
  output logic             Stuck_Low
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d, duty_q, duty_d, period_q, period_d;
  logic sv_q, sv_d, sh_q, sh_d, sl_q, sl_d;
  logic s, rise, fall;
  logic [CNT_W-1:0] per_inc, hi_inc;
  logic tmo;
  pulse_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (sysclk),
    .rst_ni (reset),
    .pulse_i(Pulse),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );
  // counters saturate at TIMEOUT; in IDLE per_q doubles as the idle counter
  assign per_inc = (per_q == TMO) ? per_q : per_q + ONE;
  assign hi_inc  = (hi_q == TMO) ? hi_q : hi_q + ONE;
  assign tmo     = per_q == TMO;
  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    duty_d   = duty_q;
    period_d = period_q;
    sv_d     = 1'b0;
    if (!En) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
    end else if (rise) begin
      // a rise always wins over a simultaneous timeout
      state_d = HIGH;
      per_d   = ONE;
      hi_d    = ONE;
      if (state_q == LOW) begin
        duty_d   = hi_q;
        period_d = per_q;
        sv_d     = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          per_d   = per_inc;
          state_d = tmo ? STUCK : IDLE;
        end
        HIGH: begin
          per_d   = per_inc;
          hi_d    = s ? hi_inc : hi_q;
          state_d = fall ? LOW : tmo ? STUCK : HIGH;
        end
        LOW: begin
          per_d   = per_inc;
          state_d = tmo ? STUCK : LOW;
        end
        STUCK: state_d = STUCK;
      endcase
    end
    // flags follow the line level for as long as we sit in STUCK
    sh_d = (state_d == STUCK) & s;
    sl_d = (state_d == STUCK) & ~s;
  end
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      duty_q   <= '0;
      period_q <= '0;
      sv_q     <= 1'b0;
      sh_q     <= 1'b0;
      sl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      sv_q     <= sv_d;
      sh_q     <= sh_d;
      sl_q     <= sl_d;
    end
  end
  assign Duty         = duty_q;
  assign Period       = period_q;
  assign Sample_Valid = sv_q;
  assign Stuck_High   = sh_q;
  assign Stuck_Low    = sl_q;
endmodule
